// File: rtl/mem_link_pkg.sv
// Shared definitions for the memory-link initiator: message lengths, field
// positions inside the 72-bit channel payload, FSM state encoding and the
// registered request record.
package mem_link_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int LEN_W  = 5;
    localparam int MSG_W  = 72;

    // Message lengths in bytes as carried on the channel length field.
    localparam logic [LEN_W-1:0] READ_LEN  = 5'd5;
    localparam logic [LEN_W-1:0] WRITE_LEN = 5'd9;
    localparam logic [LEN_W-1:0] RESP_LEN  = 5'd4;

    // Read request: address in the low word, bit 32 is the write flag (0).
    localparam int RD_ADDR_LSB = 0;
    localparam int RD_WE_BIT   = 32;

    // Write request: data, then address, then byte mask; top nibble zero.
    localparam int WR_DATA_LSB = 0;
    localparam int WR_ADDR_LSB = 32;
    localparam int WR_MASK_LSB = 64;

    // Read response: data in the low word.
    localparam int RESP_DATA_LSB = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] mask;
    } req_t;

endpackage

// File: rtl/mem_link_pack.sv
// Outbound message formatter: turns the registered CPU request into the
// channel length/payload pair. Purely combinational; drives zero whenever
// the initiator is not offering a message.
module mem_link_pack
    import mem_link_pkg::*;
(
    input  logic             active,
    input  req_t             req,
    output logic [LEN_W-1:0] send_length,
    output logic [MSG_W-1:0] send_data
);

    // Build the read or write message layout from the request fields.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // block leaves it unassigned, which would infer a latch.
        send_length = '0;
        send_data   = '0;
        if (active) begin
            if (req.we) begin
                send_length                      = WRITE_LEN;
                send_data[WR_DATA_LSB +: DATA_W] = req.wdata;
                send_data[WR_ADDR_LSB +: ADDR_W] = req.addr;
                send_data[WR_MASK_LSB +: MASK_W] = req.mask;
            end else begin
                send_length                      = READ_LEN;
                send_data[RD_ADDR_LSB +: ADDR_W] = req.addr;
                send_data[RD_WE_BIT]             = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_link_initiator.sv
// Memory-link initiator: accepts one CPU load/store at a time, sends it as a
// message on the outbound channel and, for reads, waits for the 4-byte
// response on the inbound channel. Writes complete right after sending.
// Inbound messages that are not an expected response are popped and flagged
// on proto_err.
//
// Optional feature: define MEM_LINK_TIMEOUT_EN to build a response watchdog
// that completes a read with resp_err after TIMEOUT_CYCLES cycles of waiting.
module mem_link_initiator
    import mem_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    // CPU side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_mask,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    // outbound channel
    output logic              send_flag,
    output logic [LEN_W-1:0]  send_length,
    output logic [MSG_W-1:0]  send_data,
    input  logic              writable,
    // inbound channel
    output logic              recv_flag,
    input  logic [LEN_W-1:0]  recv_length,
    input  logic [MSG_W-1:0]  recv_data,
    input  logic              readable,
    output logic              proto_err
);

    state_e            state;
    state_e            state_next;
    req_t              req_q;

    logic              resp_valid_d;
    logic              recv_flag_d;
    logic              proto_err_d;
    logic [DATA_W-1:0] rdata_d;
    logic              msg_seen;

    // Only the low word of a response carries data.
    logic [MSG_W-DATA_W-1:0] unused_recv_bits;
    assign unused_recv_bits = recv_data[MSG_W-1:DATA_W];

`ifdef MEM_LINK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             resp_err_d;

    assign timeout_hit = (state == WAIT_RESP) &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts cycles spent in WAIT_RESP, cleared everywhere else.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wait_cnt <= '0;
        end else if (state != WAIT_RESP) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Registered timeout completion flag, paired with resp_valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            resp_err <= 1'b0;
        end else begin
            resp_err <= resp_err_d;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign resp_err = 1'b0;
`endif

    // An inbound message is looked at only when it has not already been
    // popped in this cycle; readable is still high while recv_flag pulses.
    assign msg_seen  = readable && !recv_flag;
    assign req_ready = (state == IDLE);

    mem_link_pack u_pack (
        .active      (state == SEND),
        .req         (req_q),
        .send_length (send_length),
        .send_data   (send_data)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    // Capture the CPU request when it is accepted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            req_q <= '0;
        end else if (req_valid && req_ready) begin
            req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, mask: req_mask};
        end
    end

    // Next-state logic plus the next values of the registered pulses.
    always_comb begin
        state_next   = state;
        send_flag    = 1'b0;
        resp_valid_d = 1'b0;
        recv_flag_d  = 1'b0;
        proto_err_d  = 1'b0;
        rdata_d      = resp_rdata;
`ifdef MEM_LINK_TIMEOUT_EN
        resp_err_d   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = SEND;
                end
                if (msg_seen) begin
                    recv_flag_d = 1'b1;
                    proto_err_d = 1'b1;
                end
            end
            SEND: begin
                if (writable) begin
                    send_flag = 1'b1;
                    if (req_q.we) begin
                        resp_valid_d = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        state_next   = WAIT_RESP;
                    end
                end
                if (msg_seen) begin
                    recv_flag_d = 1'b1;
                    proto_err_d = 1'b1;
                end
            end
            WAIT_RESP: begin
                if (msg_seen && recv_length == RESP_LEN) begin
                    rdata_d      = recv_data[RESP_DATA_LSB +: DATA_W];
                    recv_flag_d  = 1'b1;
                    resp_valid_d = 1'b1;
                    state_next   = IDLE;
                end else begin
                    if (msg_seen) begin
                        recv_flag_d = 1'b1;
                        proto_err_d = 1'b1;
                    end
`ifdef MEM_LINK_TIMEOUT_EN
                    if (timeout_hit) begin
                        rdata_d      = '0;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        state_next   = IDLE;
                    end
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered completion and channel-pop pulses plus read data.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            resp_valid <= 1'b0;
            recv_flag  <= 1'b0;
            proto_err  <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= resp_valid_d;
            recv_flag  <= recv_flag_d;
            proto_err  <= proto_err_d;
            resp_rdata <= rdata_d;
        end
    end

endmodule

// File: doc/mem_link_initiator.md
MEM_LINK_INITIATOR -- requirements
Module: mem_link_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, response-wait limit in clock cycles (used only when MEM_LINK_TIMEOUT_EN is defined).
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports req_valid input 1, req_ready output 1: CPU request handshake.
REQ-005 SHALL have ports req_we input 1, req_addr input 32, req_wdata input 32, req_mask input 4: write enable, byte address, write data, byte-enable.
REQ-006 SHALL have ports resp_valid output 1 (one-cycle completion pulse), resp_rdata output 32 (read data), resp_err output 1 (timeout completion flag).
REQ-007 SHALL have ports send_flag output 1, send_length output 5, send_data output 72, writable input 1: outbound channel message.
REQ-008 SHALL have ports recv_flag output 1, recv_length input 5, recv_data input 72, readable input 1: inbound channel message.
REQ-009 SHALL have port proto_err output 1: one-cycle pulse on a dropped inbound message.

Function
REQ-010 SHALL implement states IDLE, SEND, WAIT_RESP; req_ready=1 only in IDLE.
REQ-011 SHALL register req_we/addr/wdata/mask on req_valid&&req_ready and move IDLE->SEND.
REQ-012 SHALL format a read as send_length=5, send_data[31:0]=addr, send_data[32]=0, other bits 0.
REQ-013 SHALL format a write as send_length=9, send_data[31:0]=wdata, [63:32]=addr, [67:64]=mask, [71:68]=0.
REQ-014 SHALL, in SEND with writable=1, pulse send_flag for exactly one cycle with length/data stable that cycle; in SEND with writable=0, wait with send_flag=0 indefinitely.
REQ-015 SHALL, after a write send, pulse resp_valid the following cycle with resp_rdata unchanged and return to IDLE (no response is expected).
REQ-016 SHALL, after a read send, enter WAIT_RESP.
REQ-017 SHALL, in WAIT_RESP, sample readable only while recv_flag=0 (no double-consume).
REQ-018 SHALL, in WAIT_RESP with readable=1 and recv_length=4, register resp_rdata=recv_data[31:0], then pulse recv_flag and resp_valid together the next cycle and return to IDLE.
REQ-019 SHALL, on readable=1 with recv_length!=4 in WAIT_RESP, or readable=1 in IDLE/SEND, pulse recv_flag and proto_err for one cycle, drop the message and keep state.
REQ-020 SHALL keep resp_err=0 except as in REQ-025.
REQ-021 SHALL, in a read with resp_valid and a new req_valid in the same cycle, accept the new request (state is IDLE).

Reset
REQ-022 SHALL, while RST=0, force state IDLE and send_flag, recv_flag, resp_valid, resp_err, proto_err, send_length, send_data, resp_rdata to 0, with no send_flag or recv_flag pulse on release.
REQ-023 SHALL abandon any in-flight request on reset mid-operation, without completion pulse.

Configuration
REQ-024 SHALL compile a response watchdog only when macro MEM_LINK_TIMEOUT_EN is defined.
REQ-025 SHALL, with MEM_LINK_TIMEOUT_EN, count WAIT_RESP cycles from 0; on reaching TIMEOUT_CYCLES pulse resp_valid and resp_err together, resp_rdata=0, and go IDLE; a late response is dropped per REQ-019.
REQ-026 SHALL, without MEM_LINK_TIMEOUT_EN, wait in WAIT_RESP indefinitely and tie resp_err to 0.

Structure
REQ-027 SHALL place message lengths (READ_LEN=5, WRITE_LEN=9, RESP_LEN=4), field bit positions and state encodings in shared package mem_link_pkg.
REQ-028 SHALL use one sub-module, mem_link_pack, combinationally building send_length/send_data from registered request fields.

Verification
REQ-029 SHALL cover: read addr 0x100 -> send_length=5, send_data=0x0000000100; responder returns length 4, 0xDEADBEEF -> resp_valid with resp_rdata=0xDEADBEEF and recv_flag in the same cycle.
REQ-030 SHALL cover: write addr 0x20, wdata 0x11223344, mask 0b0101 -> send_length=9, send_data=0x0500000020_11223344, resp_valid one cycle after send_flag.
REQ-031 SHALL cover: writable held 0 for 10 cycles during SEND -> no send_flag, req_ready=0; writable=1 -> one send_flag.
REQ-032 SHALL cover: stray length-9 message in WAIT_RESP -> recv_flag+proto_err pulse, still WAIT_RESP; then length-4 response completes normally.
REQ-033 SHALL cover: with MEM_LINK_TIMEOUT_EN, TIMEOUT_CYCLES=8 and no response -> resp_valid+resp_err 8 cycles after WAIT_RESP entry, resp_rdata=0.
REQ-034 SHALL cover: RST=0 in WAIT_RESP -> all outputs 0 at once, IDLE; after release a new read completes normally.
